ddram_responder: RTL and testbench

//   Synthesizable responder for the 64-bit DDRAM burst interface. It is the memory end
//   of the interface that core-side DDRAM clients drive. Requests are served from an
//   on-chip 64-bit block RAM. It replaces HPS DDR in simulation and on DDR-less builds,
//   and can inject BUSY backpressure to stress clients.
//

---
 rtl/ddram_responder_if.sv | 40 ++++
 rtl/ddram_responder.sv | 170 +++++++++++++++++
 tb/tb_ddram_responder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddram_responder_if.sv
// Bundle of the 64-bit DDRAM burst interface between a core-side client
// (master) and the memory end (slave).
//
// Handshake: a command or write beat is transferred at a rising clock edge
// where the client holds DDRAM_RD or DDRAM_WE high and DDRAM_BUSY is low.
// DDRAM_BUSY never depends on the request inputs in the same cycle.
// Read data carries no backpressure: every cycle with DDRAM_DOUT_READY high
// is one beat, and the client must take it.
//
// Signals:
//   DDRAM_BUSY        slave -> master  waitrequest
//   DDRAM_BURSTCNT    master -> slave  burst length in beats (0 means 1)
//   DDRAM_ADDR        master -> slave  64-bit word address
//   DDRAM_DOUT        slave -> master  read data beat
//   DDRAM_DOUT_READY  slave -> master  read beat valid
//   DDRAM_RD          master -> slave  read command request
//   DDRAM_DIN         master -> slave  write data beat
//   DDRAM_BE          master -> slave  write byte enables
//   DDRAM_WE          master -> slave  write beat request
interface ddram_responder_if;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/ddram_responder.sv
// Memory end of the 64-bit DDRAM burst interface, backed by an on-chip
// 2^AW x 64-bit RAM. Serves read and write bursts and can inject one-cycle
// BUSY stalls to stress clients.
//
// Ports:
//   DDRAM_CLK      in   clock, rising edge
//   DDRAM_RESET_N  in   asynchronous active-low reset
//   bus            slave side of ddram_responder_if
//   proto_err      out  sticky protocol-violation flag, cleared only by reset
//   dbg_state_o    out  current FSM state (IDLE=0, WR_BURST=1, RD_WAIT=2, RD_BURST=3)
module ddram_responder #(
    parameter int         AW          = 10,
    parameter logic [3:0] BASE        = 4'b0011,
    parameter int         RD_LAT      = 2,
    parameter int         STALL_EVERY = 0
) (
    input  logic                DDRAM_CLK,
    input  logic                DDRAM_RESET_N,
    ddram_responder_if.slave    bus,
    output logic                proto_err,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

    localparam int SCW = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;
    localparam int LCW = $clog2(RD_LAT + 1);

    logic [63:0] mem_q [0:2**AW-1];

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    beat_q, beat_d;
    logic          win_q, win_d;
    logic [LCW-1:0] wait_q, wait_d;
    logic [SCW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
    logic [63:0]   dout_q;
    logic          rdy_q;

    logic          stall, busy, acc_rd, acc_we;
    logic [7:0]    cmd_len;
    logic          cmd_win;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          rd_fire;
    logic [AW-1:0] rd_idx;

    // Stall and busy come from registered state only, so BUSY never
    // combinationally depends on the client's request lines.
    assign stall = (STALL_EVERY > 0) && (state_q == IDLE || state_q == WR_BURST)
                   && (stall_q == SCW'(STALL_EVERY));
    assign busy    = stall || state_q == RD_WAIT || state_q == RD_BURST;
    assign acc_rd  = bus.DDRAM_RD && !busy;
    assign acc_we  = bus.DDRAM_WE && !busy;
    assign cmd_len = (bus.DDRAM_BURSTCNT == 8'd0) ? 8'd1 : bus.DDRAM_BURSTCNT;
    assign cmd_win = (bus.DDRAM_ADDR[28:25] == BASE);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        beat_d    = beat_q;
        win_d     = win_q;
        wait_d    = wait_q;
        stall_d   = stall_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = base_q + AW'(beat_q);
        rd_fire   = 1'b0;
        rd_idx    = base_q + AW'(beat_q);

        if (STALL_EVERY > 0 && (state_q == IDLE || state_q == WR_BURST)) begin
            stall_d = stall ? '0 : stall_q + SCW'(1);
        end

        case (state_q)
            IDLE: begin
                if (acc_we) begin
                    // Write wins over a simultaneous read; the read is dropped.
                    mem_we    = cmd_win;
                    mem_waddr = bus.DDRAM_ADDR[AW-1:0];
                    base_d    = bus.DDRAM_ADDR[AW-1:0];
                    len_d     = cmd_len;
                    win_d     = cmd_win;
                    beat_d    = 8'd1;
                    if (cmd_len != 8'd1) state_d = WR_BURST;
                    if (acc_rd) err_d = 1'b1;
                end else if (acc_rd) begin
                    base_d  = bus.DDRAM_ADDR[AW-1:0];
                    len_d   = cmd_len;
                    win_d   = cmd_win;
                    beat_d  = 8'd0;
                    wait_d  = '0;
                    state_d = RD_WAIT;
                end
            end
            WR_BURST: begin
                if (acc_we) begin
                    mem_we = win_q;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q - 8'd1) state_d = IDLE;
                end
                if (acc_rd) err_d = 1'b1;
            end
            RD_WAIT: begin
                // The last wait cycle issues the RAM read for beat 0, so the
                // registered beat appears RD_LAT edges after the accept.
                if (wait_q == LCW'(RD_LAT - 1)) begin
                    rd_fire = 1'b1;
                    beat_d  = beat_q + 8'd1;
                    state_d = RD_BURST;
                end else begin
                    wait_d = wait_q + LCW'(1);
                end
            end
            RD_BURST: begin
                if (beat_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    rd_fire = 1'b1;
                    beat_d  = beat_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= 8'd1;
            beat_q  <= 8'd0;
            win_q   <= 1'b0;
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
            dout_q  <= 64'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            win_q   <= win_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            rdy_q   <= rd_fire;
            // DOUT holds the last beat between bursts.
            if (rd_fire) dout_q <= win_q ? mem_q[rd_idx] : 64'd0;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge DDRAM_CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.DDRAM_BE[i]) mem_q[mem_waddr][8*i +: 8] <= bus.DDRAM_DIN[8*i +: 8];
            end
        end
    end

    assign bus.DDRAM_BUSY       = busy;
    assign bus.DDRAM_DOUT       = dout_q;
    assign bus.DDRAM_DOUT_READY = rdy_q;
    assign proto_err            = err_q;
    assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_ddram_responder.sv
module tb_ddram_responder;
    localparam int RD_LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst0_n, rst1_n;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    ddram_responder_if if0();
    ddram_responder_if if1();

    // Shared client drive, steered to one DUT by sel.
    logic        drv_rd, drv_we;
    logic [28:0] drv_addr;
    logic [7:0]  drv_bc, drv_be;
    logic [63:0] drv_din;
    int          sel;

    assign if0.DDRAM_RD       = drv_rd && (sel == 0);
    assign if0.DDRAM_WE       = drv_we && (sel == 0);
    assign if0.DDRAM_ADDR     = drv_addr;
    assign if0.DDRAM_BURSTCNT = drv_bc;
    assign if0.DDRAM_DIN      = drv_din;
    assign if0.DDRAM_BE       = drv_be;
    assign if1.DDRAM_RD       = drv_rd && (sel == 1);
    assign if1.DDRAM_WE       = drv_we && (sel == 1);
    assign if1.DDRAM_ADDR     = drv_addr;
    assign if1.DDRAM_BURSTCNT = drv_bc;
    assign if1.DDRAM_DIN      = drv_din;
    assign if1.DDRAM_BE       = drv_be;

    logic       perr0, perr1;
    logic [1:0] st0, st1;

    ddram_responder #(.AW(10), .BASE(4'b1000), .RD_LAT(RD_LAT), .STALL_EVERY(0)) dut0 (
        .DDRAM_CLK(clk), .DDRAM_RESET_N(rst0_n), .bus(if0),
        .proto_err(perr0), .dbg_state_o(st0)
    );
    ddram_responder #(.AW(10), .BASE(4'b1000), .RD_LAT(RD_LAT), .STALL_EVERY(4)) dut1 (
        .DDRAM_CLK(clk), .DDRAM_RESET_N(rst1_n), .bus(if1),
        .proto_err(perr1), .dbg_state_o(st1)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    int          exp_cyc_q0[$];
    int          exp_cyc_q1[$];
    int          seen0 = 0;
    int          seen1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (if0.DDRAM_DOUT_READY === 1'b1) begin
            seen0++;
            if (exp_q0.size() == 0 || exp_cyc_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat0 actual=%h required=no_beat", if0.DDRAM_DOUT);
            end else begin
                check("beat0_data", if0.DDRAM_DOUT, exp_q0.pop_front());
                check("beat0_cycle", 64'(cyc), 64'(exp_cyc_q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (if1.DDRAM_DOUT_READY === 1'b1) begin
            seen1++;
            if (exp_q1.size() == 0 || exp_cyc_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat1 actual=%h required=no_beat", if1.DDRAM_DOUT);
            end else begin
                check("beat1_data", if1.DDRAM_DOUT, exp_q1.pop_front());
                check("beat1_cycle", 64'(cyc), 64'(exp_cyc_q1.pop_front()));
            end
        end
    end

    // ---------------- driver tasks (entered and left just after a negedge) ----------------
    function automatic logic cur_busy();
        return (sel == 1) ? if1.DDRAM_BUSY : if0.DDRAM_BUSY;
    endfunction

    task automatic wait_not_busy(input string name);
        int g = 0;
        while (cur_busy() !== 1'b0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s actual=busy_timeout required=busy_low", name);
        end
    endtask

    task automatic do_write(input logic [28:0] a, input int len, input logic [63:0] d0,
                            input logic [7:0] be);
        for (int i = 0; i < len; i++) begin
            drv_we   = 1'b1;
            drv_addr = a;
            drv_bc   = 8'(len);
            drv_din  = d0 + 64'(i);
            drv_be   = be;
            wait_not_busy("wr_busy_wait");
            @(posedge clk);
            @(negedge clk);
        end
        drv_we = 1'b0;
    endtask

    task automatic do_read(input logic [28:0] a, input int len, input int hold);
        int l = (len == 0) ? 1 : len;
        int t;
        drv_rd   = 1'b1;
        drv_addr = a;
        drv_bc   = 8'(len);
        wait_not_busy("rd_busy_wait");
        t = cyc + 1;
        for (int k = 0; k < l; k++) begin
            if (sel == 1) exp_cyc_q1.push_back(t + RD_LAT + k);
            else          exp_cyc_q0.push_back(t + RD_LAT + k);
        end
        @(posedge clk);
        @(negedge clk);
        repeat (hold) @(negedge clk);
        drv_rd = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q0.size() + exp_q1.size()) > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        check("drain0", 64'(exp_q0.size()), 64'd0);
        check("drain1", 64'(exp_q1.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s, g;
        drv_rd = 1'b0; drv_we = 1'b0; drv_addr = '0; drv_bc = '0; drv_din = '0; drv_be = '0;
        sel = 0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(if0.DDRAM_BUSY), 64'd0);
            check("idle_ready", 64'(if0.DDRAM_DOUT_READY), 64'd0);
            check("idle_dout", if0.DDRAM_DOUT, 64'd0);
            check("idle_perr", 64'(perr0), 64'd0);
        end

        // Byte-enabled write on a zeroed word, then read-after-write.
        do_write(29'h1000_0010, 1, 64'd0, 8'hFF);
        do_write(29'h1000_0010, 1, 64'h1122334455667788, 8'h0F);
        exp_q0.push_back(64'h0000000055667788);
        do_read(29'h1000_0010, 1, 0);
        wait_drain();
        check("dout_hold", if0.DDRAM_DOUT, 64'h0000000055667788);
        check("ready_low", 64'(if0.DDRAM_DOUT_READY), 64'd0);

        // Wrapping burst at the top of the RAM.
        do_write(29'h1000_03FE, 4, 64'd1, 8'hFF);
        exp_q0.push_back(64'd1); exp_q0.push_back(64'd2);
        exp_q0.push_back(64'd3); exp_q0.push_back(64'd4);
        do_read(29'h1000_03FE, 4, 0);
        exp_q0.push_back(64'd3); exp_q0.push_back(64'd4);
        do_read(29'h1000_0000, 2, 0);
        exp_q0.push_back(64'd1);
        do_read(29'h1000_03FE, 0, 0);
        wait_drain();

        // Out-of-window write dropped; out-of-window read returns zeros.
        do_write(29'h0000_0010, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        exp_q0.push_back(64'h0000000055667788);
        do_read(29'h1000_0010, 1, 0);
        exp_q0.push_back(64'd0); exp_q0.push_back(64'd0);
        do_read(29'h0000_0010, 2, 0);
        wait_drain();

        // Reset in the middle of a read burst.
        do_write(29'h1000_0100, 8, 64'h100, 8'hFF);
        exp_q0.push_back(64'h100); exp_q0.push_back(64'h101); exp_q0.push_back(64'h102);
        s = seen0;
        do_read(29'h1000_0100, 8, 0);
        g = 0;
        while (seen0 < s + 3 && g < 50) begin
            @(negedge clk);
            #2;
            g++;
        end
        check("three_beats_seen", 64'(seen0 - s), 64'd3);
        rst0_n = 1'b0;
        #1;
        check("rst_ready", 64'(if0.DDRAM_DOUT_READY), 64'd0);
        check("rst_busy", 64'(if0.DDRAM_BUSY), 64'd0);
        check("rst_dout", if0.DDRAM_DOUT, 64'd0);
        check("rst_state", 64'(st0), 64'd0);
        check("rst_pending", 64'(exp_q0.size()), 64'd0);
        exp_cyc_q0.delete();
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        exp_q0.push_back(64'h103); exp_q0.push_back(64'h104);
        do_read(29'h1000_0103, 2, 0);
        wait_drain();

        // Stall injection on dut1: read held through a BUSY stall.
        sel = 1;
        do_write(29'h1000_0005, 2, 64'hA0, 8'hFF);
        g = 0;
        while (if1.DDRAM_BUSY !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("stall_seen", 64'(if1.DDRAM_BUSY), 64'd1);
        exp_q1.push_back(64'hA0); exp_q1.push_back(64'hA1);
        s = seen1;
        do_read(29'h1000_0005, 2, 3);
        wait_drain();
        check("pulse_count", 64'(seen1 - s), 64'd2);

        // RD and WE together: write served, read dropped, sticky error.
        check("perr1_before", 64'(perr1), 64'd0);
        drv_rd = 1'b1; drv_we = 1'b1;
        drv_addr = 29'h1000_0009; drv_bc = 8'd1; drv_din = 64'h55; drv_be = 8'hFF;
        wait_not_busy("rdwe_busy_wait");
        @(posedge clk);
        @(negedge clk);
        drv_rd = 1'b0; drv_we = 1'b0;
        check("perr1_set", 64'(perr1), 64'd1);
        repeat (6) @(negedge clk);
        check("perr1_sticky", 64'(perr1), 64'd1);
        check("perr0_clear", 64'(perr0), 64'd0);
        check("rdwe_state", 64'(st1 == 2'd1 || st1 == 2'd2 || st1 == 2'd3), 64'd0);
        exp_q1.push_back(64'h55);
        do_read(29'h1000_0009, 1, 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
